adt7410_poller: RTL and testbench

- Sequencer in front of the i2c_wrapper transaction engine.
- Configures the ADT7410 temperature sensor once, then periodically reads the 16-bit temperature as two single-byte register reads (0x00 MSB, 0x01 LSB).
- Publishes each complete sample atomically.
- Handles bus errors and hung transactions with bounded retries and a sticky fault flag; sits between board-level logic (display, LEDs) and i2c_wrapper.

---
 rtl/adt7410_poller.sv | 188 ++++++++++++++++++
 tb/tb_adt7410_poller.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adt7410_poller.sv
// ADT7410 sequencer: one configuration write, then periodic MSB/LSB temperature reads
// through the i2c_wrapper handshake, with bounded retries, timeouts and a sticky fault.
module adt7410_poller #(
    parameter int unsigned CLK_FREQ       = 100_000_000,
    parameter int unsigned POLL_CYCLES    = 25_000_000,
    parameter logic [7:0]  CFG_REG        = 8'h03,
    parameter logic [7:0]  CFG_VALUE      = 8'h80,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        force_poll,
    output logic        i2c_start,
    output logic        i2c_rd_wr,
    output logic [7:0]  i2c_address,
    output logic [7:0]  i2c_data_to_send,
    input  logic [7:0]  i2c_data_received,
    input  logic        i2c_busy,
    input  logic        i2c_error,
    output logic [15:0] temp_data,
    output logic        temp_valid,
    output logic        cfg_done,
    output logic        fault
);

    localparam int          RW         = $clog2(MAX_RETRIES + 2);
    localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
    localparam logic [31:0] POLL_LAST  = 32'(POLL_CYCLES - 1);
    localparam logic [31:0] TMO_LIMIT  = 32'(TIMEOUT_CYCLES);

    generate
        if (CLK_FREQ == 0 || POLL_CYCLES == 0 || TIMEOUT_CYCLES == 0) begin : g_bad_params
            $error("adt7410_poller: CLK_FREQ, POLL_CYCLES and TIMEOUT_CYCLES must be non-zero");
        end
    endgenerate

    typedef enum logic [3:0] {
        S_IDLE, S_CFG_ISSUE, S_CFG_WAIT, S_MSB_ISSUE, S_MSB_WAIT,
        S_LSB_ISSUE, S_LSB_WAIT, S_PUBLISH, S_WAIT_TIMER
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   cnt_q, cnt_d;
    logic [RW-1:0] retry_q, retry_d;
    logic          busy_seen_q, busy_seen_d;
    logic [7:0]    msb_q, msb_d;
    logic [15:0]   temp_q, temp_d;
    logic          cfg_done_q, cfg_done_d;
    logic          fault_q, fault_d;

    logic txn_done, txn_ok, txn_fail;

    function automatic state_t issue_of(state_t s);
        case (s)
            S_CFG_WAIT: return S_CFG_ISSUE;
            S_MSB_WAIT: return S_MSB_ISSUE;
            default:    return S_LSB_ISSUE;
        endcase
    endfunction

    // Completion needs busy to have been seen high first, so the idle bus right after start is not mistaken for it.
    assign txn_done = busy_seen_q && !i2c_busy;
    assign txn_ok   = txn_done && !i2c_error;
    assign txn_fail = (txn_done && i2c_error) || (!txn_done && (cnt_q >= TMO_LIMIT));

    always_comb begin
        state_d          = state_q;
        cnt_d            = cnt_q + 32'd1;
        retry_d          = retry_q;
        busy_seen_d      = busy_seen_q;
        msb_d            = msb_q;
        temp_d           = temp_q;
        cfg_done_d       = cfg_done_q;
        fault_d          = fault_q;
        i2c_start        = 1'b0;
        i2c_rd_wr        = 1'b0;
        i2c_address      = 8'h00;
        i2c_data_to_send = 8'h00;
        temp_valid       = 1'b0;

        case (state_q)
            S_CFG_ISSUE, S_CFG_WAIT: begin
                i2c_address      = CFG_REG;
                i2c_data_to_send = CFG_VALUE;
            end
            S_MSB_ISSUE, S_MSB_WAIT: begin
                i2c_rd_wr   = 1'b1;
                i2c_address = 8'h00;
            end
            S_LSB_ISSUE, S_LSB_WAIT: begin
                i2c_rd_wr   = 1'b1;
                i2c_address = 8'h01;
            end
            default: ;
        endcase

        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = cfg_done_q ? S_MSB_ISSUE : S_CFG_ISSUE;
                end
            end
            S_CFG_ISSUE, S_MSB_ISSUE, S_LSB_ISSUE: begin
                if (!i2c_busy) begin
                    i2c_start   = 1'b1;
                    cnt_d       = 32'd1;
                    busy_seen_d = 1'b0;
                    state_d     = (state_q == S_CFG_ISSUE) ? S_CFG_WAIT :
                                  (state_q == S_MSB_ISSUE) ? S_MSB_WAIT : S_LSB_WAIT;
                end
            end
            S_CFG_WAIT, S_MSB_WAIT, S_LSB_WAIT: begin
                busy_seen_d = busy_seen_q | i2c_busy;
                if (txn_ok) begin
                    retry_d = '0;
                    case (state_q)
                        S_CFG_WAIT: begin
                            cfg_done_d = 1'b1;
                            state_d    = enable ? S_MSB_ISSUE : S_IDLE;
                        end
                        S_MSB_WAIT: begin
                            msb_d   = i2c_data_received;
                            state_d = enable ? S_LSB_ISSUE : S_IDLE;
                        end
                        default: begin
                            // A finished sample is published even if enable dropped during the LSB read.
                            temp_d  = {msb_q, i2c_data_received};
                            fault_d = 1'b0;
                            state_d = S_PUBLISH;
                        end
                    endcase
                end else if (txn_fail) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 1'b1;
                        state_d = issue_of(state_q);
                    end else begin
                        retry_d = '0;
                        fault_d = 1'b1;
                        cnt_d   = 32'd0;
                        state_d = enable ? S_WAIT_TIMER : S_IDLE;
                    end
                end
            end
            S_PUBLISH: begin
                temp_valid = 1'b1;
                cnt_d      = 32'd0;
                state_d    = S_WAIT_TIMER;
            end
            S_WAIT_TIMER: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (force_poll || (cnt_q == POLL_LAST)) begin
                    state_d = S_MSB_ISSUE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            retry_q     <= '0;
            busy_seen_q <= 1'b0;
            msb_q       <= '0;
            temp_q      <= '0;
            cfg_done_q  <= 1'b0;
            fault_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            retry_q     <= retry_d;
            busy_seen_q <= busy_seen_d;
            msb_q       <= msb_d;
            temp_q      <= temp_d;
            cfg_done_q  <= cfg_done_d;
            fault_q     <= fault_d;
        end
    end

    assign temp_data = temp_q;
    assign cfg_done  = cfg_done_q;
    assign fault     = fault_q;

endmodule

// File: tb/tb_adt7410_poller.sv
// Bench for adt7410_poller: behavioural i2c_wrapper model, directed sequences,
// a table of retry scenarios and a randomized run checked by a transaction-level model.
module tb_adt7410_poller;

    localparam int POLL = 100;
    localparam int TMO  = 50;
    localparam int MAXR = 3;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        enable = 1'b0;
    logic        force_poll = 1'b0;
    logic        i2c_start, i2c_rd_wr;
    logic [7:0]  i2c_address, i2c_data_to_send;
    logic [7:0]  i2c_data_received = 8'h00;
    logic        i2c_busy = 1'b0;
    logic        i2c_error = 1'b0;
    logic [15:0] temp_data;
    logic        temp_valid, cfg_done, fault;

    adt7410_poller #(
        .CLK_FREQ(100_000_000), .POLL_CYCLES(POLL), .CFG_REG(8'h03), .CFG_VALUE(8'h80),
        .MAX_RETRIES(MAXR), .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk), .rst_n(rst_n), .enable(enable), .force_poll(force_poll),
        .i2c_start(i2c_start), .i2c_rd_wr(i2c_rd_wr), .i2c_address(i2c_address),
        .i2c_data_to_send(i2c_data_to_send), .i2c_data_received(i2c_data_received),
        .i2c_busy(i2c_busy), .i2c_error(i2c_error), .temp_data(temp_data),
        .temp_valid(temp_valid), .cfg_done(cfg_done), .fault(fault)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [7:0] addr; logic rdwr; logic [7:0] wdata;
        logic err; logic [7:0] rdata; int start_cyc; int done_cyc;
    } tx_t;
    typedef struct { logic [15:0] data; int cyc; } pub_t;
    typedef struct {
        int msb_err; int lsb_err; logic [7:0] msb; logic [7:0] lsb;
        int n_msb; int n_lsb; int n_pub; logic fault; logic [15:0] temp;
    } vec_t;

    tx_t  txq[$];
    pub_t pubq[$];
    int   hold_q[$];
    int   err_left[2];
    logic [7:0] ret_val[2];
    int   err_pct = 0;
    bit   rand_data = 1'b0;
    int   start_count = 0;
    int   last_start_cyc = 0;

    int total = 0;
    int bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Wrapper model: busy rises the cycle after start, holds, then falls with error and data.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && i2c_start) begin
                tx_t t;
                int hold;
                int idx;
                logic e;
                logic [7:0] d;
                t.addr = i2c_address; t.rdwr = i2c_rd_wr; t.wdata = i2c_data_to_send;
                t.start_cyc = cyc;
                hold = (hold_q.size() > 0) ? hold_q.pop_front() : 4;
                e = 1'b0; d = 8'h00;
                if (t.rdwr && t.addr <= 8'h01) begin
                    idx = int'(t.addr);
                    d = rand_data ? 8'($urandom) : ret_val[idx];
                    if (err_left[idx] > 0) begin e = 1'b1; err_left[idx]--; end
                end
                if (err_pct > 0 && $urandom_range(99, 0) < err_pct) e = 1'b1;
                t.err = e; t.rdata = d;
                @(posedge clk); #1;
                i2c_busy = 1'b1; i2c_error = 1'b0;
                for (int k = 0; k < hold && rst_n; k++) @(posedge clk);
                #1;
                i2c_busy = 1'b0; i2c_error = e; i2c_data_received = d;
                t.done_cyc = cyc;
                txq.push_back(t);
                $display("tx addr=%02h rw=%0d wdata=%02h err=%0d rdata=%02h start=%0d done=%0d",
                         t.addr, t.rdwr, t.wdata, t.err, t.rdata, t.start_cyc, t.done_cyc);
            end
        end
    end

    always @(negedge clk) begin
        if (temp_valid) pubq.push_back('{temp_data, cyc});
        if (i2c_start) begin start_count++; last_start_cyc = cyc; end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_tx(input int n, input int budget, input string nm);
        int k = 0;
        while (txq.size() < n && k < budget) begin @(posedge clk); k++; end
        #1;
        check(nm, 32'(txq.size() >= n), 32'd1);
    endtask

    task automatic wait_pub(input int n, input int budget, input string nm);
        int k = 0;
        while (pubq.size() < n && k < budget) begin @(posedge clk); k++; end
        #1;
        check(nm, 32'(pubq.size() >= n), 32'd1);
    endtask

    task automatic pulse_force();
        @(posedge clk); #1 force_poll = 1'b1;
        @(posedge clk); #1 force_poll = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int base, bpub, sc0, x, k;
        int n_msb, n_lsb;

        vecs[0] = '{0, 2, 8'h12, 8'h34, 1, 3, 1, 1'b0, 16'h1234};
        vecs[1] = '{4, 0, 8'h55, 8'h66, 4, 0, 0, 1'b1, 16'h1234};
        vecs[2] = '{0, 0, 8'h19, 8'h00, 1, 1, 1, 1'b0, 16'h1900};
        vecs[3] = '{3, 0, 8'hAB, 8'hCD, 4, 1, 1, 1'b0, 16'hABCD};
        vecs[4] = '{0, 4, 8'h77, 8'h88, 1, 4, 0, 1'b1, 16'hABCD};
        vecs[5] = '{0, 0, 8'hF0, 8'h0F, 1, 1, 1, 1'b0, 16'hF00F};

        err_left[0] = 0; err_left[1] = 0;
        ret_val[0] = 8'h0C; ret_val[1] = 8'h80;

        // Reset state
        step(3);
        check("rst i2c_start", 32'(i2c_start), 0);
        check("rst cfg_done", 32'(cfg_done), 0);
        check("rst fault", 32'(fault), 0);
        check("rst temp_valid", 32'(temp_valid), 0);
        check("rst temp_data", 32'(temp_data), 0);

        // First sequence: configuration write then MSB/LSB reads
        rst_n = 1'b1; enable = 1'b1;
        wait_pub(1, 500, "first sample timeout");
        check("cfg addr", 32'(txq[0].addr), 32'h03);
        check("cfg rdwr", 32'(txq[0].rdwr), 0);
        check("cfg data", 32'(txq[0].wdata), 32'h80);
        check("msb addr", 32'(txq[1].addr), 32'h00);
        check("msb rdwr", 32'(txq[1].rdwr), 1);
        check("lsb addr", 32'(txq[2].addr), 32'h01);
        check("first temp", 32'(pubq[0].data), 32'h0C80);
        check("publish latency", 32'(pubq[0].cyc), 32'(txq[2].done_cyc + 1));
        check("cfg_done set", 32'(cfg_done), 1);

        // Poll period, then force_poll at cycle 10 of the wait
        wait_tx(4, 400, "periodic start timeout");
        check("poll addr", 32'(txq[3].addr), 32'h00);
        check("poll period", 32'(txq[3].start_cyc), 32'(pubq[0].cyc + 1 + POLL));
        wait_pub(2, 400, "second sample timeout");
        x = pubq[1].cyc + 11;
        while (cyc < x) begin @(posedge clk); #1; end
        force_poll = 1'b1; step(1); force_poll = 1'b0;
        wait_tx(6, 100, "forced start timeout");
        check("force start cycle", 32'(txq[5].start_cyc), 32'(pubq[1].cyc + 12));
        wait_pub(3, 200, "forced sample timeout");
        step(2);

        // Retry / fault table
        for (int i = 0; i < 6; i++) begin
            err_left[0] = vecs[i].msb_err; err_left[1] = vecs[i].lsb_err;
            ret_val[0] = vecs[i].msb; ret_val[1] = vecs[i].lsb;
            base = txq.size(); bpub = pubq.size();
            pulse_force();
            wait_tx(base + vecs[i].n_msb + vecs[i].n_lsb, 500, "vec tx timeout");
            step(4);
            n_msb = 0; n_lsb = 0;
            for (int j = base; j < txq.size(); j++) begin
                if (txq[j].addr == 8'h00) n_msb++;
                if (txq[j].addr == 8'h01) n_lsb++;
            end
            $display("vec %0d msb_reads=%0d lsb_reads=%0d pubs=%0d fault=%0d temp=%04h",
                     i, n_msb, n_lsb, pubq.size() - bpub, fault, temp_data);
            check("vec msb reads", 32'(n_msb), 32'(vecs[i].n_msb));
            check("vec lsb reads", 32'(n_lsb), 32'(vecs[i].n_lsb));
            check("vec temp_valid", 32'(pubq.size() - bpub), 32'(vecs[i].n_pub));
            check("vec fault", 32'(fault), 32'(vecs[i].fault));
            check("vec temp_data", 32'(temp_data), 32'(vecs[i].temp));
        end

        // enable dropped during the MSB read
        base = txq.size(); bpub = pubq.size();
        pulse_force();
        k = 0;
        while (!i2c_busy && k < 50) begin @(posedge clk); #1; k++; end
        enable = 1'b0;
        wait_tx(base + 1, 100, "disable tx timeout");
        step(30);
        check("disable tx count", 32'(txq.size()), 32'(base + 1));
        check("disable no publish", 32'(pubq.size()), 32'(bpub));
        enable = 1'b1; x = cyc;
        wait_tx(base + 2, 100, "reenable tx timeout");
        check("reenable addr", 32'(txq[base + 1].addr), 32'h00);
        check("reenable start", 32'(txq[base + 1].start_cyc), 32'(x + 1));
        wait_pub(bpub + 1, 200, "reenable sample timeout");
        step(2);

        // Randomized run against a transaction-level model
        txq.delete(); pubq.delete();
        rand_data = 1'b1; err_pct = 30;
        for (int i = 0; i < 1500; i++) begin
            force_poll = ($urandom_range(39, 0) == 0);
            step(1);
        end
        force_poll = 1'b0; err_pct = 0;
        wait_pub(pubq.size() + 1, 800, "random drain timeout");
        step(3);
        begin
            pub_t exp_pubs[$];
            int phase = 0, attempts = 0;
            logic [7:0] m = 8'h00;
            foreach (txq[i]) begin
                check("rand addr", 32'(txq[i].addr), 32'(phase));
                if (txq[i].err) begin
                    attempts++;
                    if (attempts > MAXR) begin attempts = 0; phase = 0; end
                end else begin
                    attempts = 0;
                    if (phase == 0) begin m = txq[i].rdata; phase = 1; end
                    else begin exp_pubs.push_back('{{m, txq[i].rdata}, txq[i].done_cyc + 1}); phase = 0; end
                end
            end
            check("rand pub count", 32'(pubq.size()), 32'(exp_pubs.size()));
            foreach (exp_pubs[i]) begin
                if (i < pubq.size()) begin
                    check("rand pub data", 32'(pubq[i].data), 32'(exp_pubs[i].data));
                    check("rand pub cycle", 32'(pubq[i].cyc), 32'(exp_pubs[i].cyc));
                end
            end
            check("rand final fault", 32'(fault), 0);
        end
        rand_data = 1'b0;

        // Slow transaction just inside the timeout: no retry
        ret_val[0] = 8'h21; ret_val[1] = 8'h43;
        base = txq.size(); bpub = pubq.size();
        hold_q.push_back(48);
        pulse_force();
        wait_pub(bpub + 1, 300, "slow sample timeout");
        check("slow tx count", 32'(txq.size() - base), 2);
        check("slow temp", 32'(temp_data), 32'h2143);

        // Hung transaction: timeout, retry as soon as busy drops, then reset mid-wait
        base = txq.size(); sc0 = start_count;
        hold_q.push_back(120); hold_q.push_back(120);
        pulse_force();
        wait_tx(base + 1, 300, "hang tx timeout");
        step(2);
        check("hang retry count", 32'(start_count), 32'(sc0 + 2));
        check("hang retry cycle", 32'(last_start_cyc), 32'(txq[base].start_cyc + 121));
        step(20);
        @(posedge clk); #3 rst_n = 1'b0; #1;
        check("async rst cfg_done", 32'(cfg_done), 0);
        check("async rst temp_data", 32'(temp_data), 0);
        check("async rst fault", 32'(fault), 0);
        check("async rst start", 32'(i2c_start), 0);
        check("async rst addr", 32'(i2c_address), 0);
        k = 0;
        while (i2c_busy && k < 200) begin @(negedge clk); k++; end
        check("model abort", 32'(i2c_busy), 0);
        txq.delete();
        step(3);
        rst_n = 1'b1;
        wait_tx(1, 300, "post reset tx timeout");
        check("post reset addr", 32'(txq[0].addr), 32'h03);
        check("post reset rdwr", 32'(txq[0].rdwr), 0);
        wait_tx(3, 300, "post reset sample timeout");
        step(3);
        check("post reset cfg_done", 32'(cfg_done), 1);
        check("post reset temp", 32'(temp_data), 32'h2143);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
